// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg7_scan_ctrl_pkg;

  // Scan phase within one digit slot: dark dead-time first, then lit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Bit positions inside a 6-bit digit field {blank, dp, hex[3:0]}.
  localparam int FLD_BLANK   = 5;
  localparam int FLD_DP      = 4;
  localparam int FLD_HEX_MSB = 3;
  localparam int FLD_HEX_LSB = 0;

  // Value of every digit register after reset: blanked, dp off, hex 0.
  localparam logic [5:0] DIGIT_RST = 6'b100000;

  // Active-low segment patterns {g,f,e,d,c,b,a}, index 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex7seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Table lookup; every nibble value has an entry so no default is needed.
  always_comb begin
    o_seg = SEG_TABLE[i_hex];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered
// digit registers; shadow contents move to the display only at frame end.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE = 4096,
  parameter int BLANK    = 64
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_addr,
  input  logic [5:0] i_wr_data,
  input  logic       i_commit,
  output logic [1:0] o_dig_sel,
  output logic [3:0] o_anode,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int              PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]   SLOT_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   BLANK_LAST = PW'(BLANK - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_dig_sel;
  scan_state_e   r_state;
  logic [5:0]    r_shadow [4];
  logic [5:0]    r_active [4];
  logic          r_busy;
  logic          r_frame_done;
  logic [3:0]    r_anode;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [5:0]    w_cur;
  logic [6:0]    w_dec_seg;

  assign w_slot_end  = (r_presc == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_dig_sel == 2'd3);
  assign w_cur       = r_active[r_dig_sel];

  hex7seg u_hex7seg (
    .i_hex (w_cur[FLD_HEX_MSB:FLD_HEX_LSB]),
    .o_seg (w_dec_seg)
  );

  // Slot timing: prescaler, digit index and blank/show phase.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_presc   <= '0;
      r_dig_sel <= 2'd0;
      r_state   <= ST_BLANK;
    end else begin
      r_presc <= r_presc + PW'(1);
      if (w_slot_end) begin
        r_dig_sel <= r_dig_sel + 2'd1;
      end
      case (r_state)
        ST_BLANK: if (r_presc == BLANK_LAST) r_state <= ST_SHOW;
        ST_SHOW:  if (w_slot_end)            r_state <= ST_BLANK;
        default:  r_state <= ST_BLANK;
      endcase
    end
  end

  // Shadow writes, pending-commit flag and frame-end shadow-to-active transfer.
  // The transfer reads shadow before any same-edge write lands.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= DIGIT_RST;
        r_active[i] <= DIGIT_RST;
      end
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end && (r_busy || i_commit)) begin
        for (int i = 0; i < 4; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_busy <= 1'b0;
      end else if (i_commit) begin
        r_busy <= 1'b1;
      end
      if (i_wr_en) begin
        r_shadow[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Display drive, one cycle behind phase and digit index. A blanked digit
  // keeps its segment pattern but enables no anode.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_anode <= 4'b1111;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else if (r_state == ST_SHOW) begin
      r_anode <= w_cur[FLD_BLANK] ? 4'b1111 : ~(4'b0001 << r_dig_sel);
      r_seg   <= w_dec_seg;
      r_dp    <= ~w_cur[FLD_DP];
    end else begin
      r_anode <= 4'b1111;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end
  end

  assign o_dig_sel    = r_dig_sel;
  assign o_anode      = r_anode;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (PRESCALE=16, BLANK=2).
module tb_seg7_scan_ctrl;

  localparam int P     = 16;
  localparam int B     = 2;
  localparam int FRAME = 4 * P;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [1:0] i_wr_addr = 2'd0;
  logic [5:0] i_wr_data = 6'd0;
  logic       i_commit = 1'b0;
  logic [1:0] o_dig_sel;
  logic [3:0] o_anode;
  logic [6:0] o_seg;
  logic       o_dp;
  logic       o_busy;
  logic       o_frame_done;

  seg7_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_commit     (i_commit),
    .o_dig_sel    (o_dig_sel),
    .o_anode      (o_anode),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset plus shadow/active digit arrays.
  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         m_t;
  logic [5:0] m_shadow [4];
  logic [5:0] m_active [4];
  logic       m_busy;
  logic [1:0] e_dig;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  int cnt2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // One clock: apply inputs, advance the model by the same edge, compare all outputs.
  task automatic step(input logic rst, input logic we, input logic [1:0] wa,
                      input logic [5:0] wd, input logic cm);
    int         presc;
    int         dig;
    logic       show;
    logic       fe;
    logic [5:0] cur;
    i_reset = rst; i_wr_en = we; i_wr_addr = wa; i_wr_data = wd; i_commit = cm;
    @(posedge clk);
    if (rst) begin
      m_t = 0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 6'b100000;
        m_active[i] = 6'b100000;
      end
      m_busy = 1'b0;
      e_fd = 1'b0; e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_dig = 2'd0;
    end else begin
      presc = m_t % P;
      dig   = (m_t / P) % 4;
      show  = (presc >= B);
      fe    = (presc == P - 1) && (dig == 3);
      cur   = m_active[dig];
      if (show) begin
        e_an  = cur[5] ? 4'hF : (4'hF ^ (4'b0001 << dig));
        e_seg = seg_ref[cur[3:0]];
        e_dp  = ~cur[4];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      e_fd = fe;
      if (fe && (m_busy || cm)) begin
        for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        m_busy = 1'b0;
      end else if (cm) begin
        m_busy = 1'b1;
      end
      if (we) m_shadow[wa] = wd;
      m_t++;
      e_dig = 2'((m_t / P) % 4);
    end
    #1;
    chk("dig_sel", 32'(o_dig_sel), 32'(e_dig));
    chk("anode", 32'(o_anode), 32'(e_an));
    chk("seg", 32'(o_seg), 32'(e_seg));
    chk("dp", 32'(o_dp), 32'(e_dp));
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("frame_done", 32'(o_frame_done), 32'(e_fd));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] d);
    step(1'b0, 1'b1, a, d, 1'b0);
  endtask

  // Idle until the model's frame phase equals ph (bounded to one frame).
  task automatic align(input int ph);
    for (int k = 0; k < FRAME; k++) begin
      if (m_t % FRAME == ph) break;
      idle();
    end
  endtask

  initial begin
    // Reset and idle: dark display, digit sequence, one frame_done per frame.
    step(1'b1, 1'b0, 2'd0, 6'd0, 1'b0);
    chk("rst_anode", 32'(o_anode), 32'hF);
    chk("rst_seg", 32'(o_seg), 32'h7F);
    step(1'b1, 1'b0, 2'd0, 6'd0, 1'b0);
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < FRAME; k++) begin
      idle();
      if (o_frame_done) cnt++;
      if (o_anode != 4'hF) cnt2++;
    end
    chk("idle_frame_done_cnt", 32'(cnt), 32'd1);
    chk("idle_anode_lit_cnt", 32'(cnt2), 32'd0);

    // Digits 1,2,3,A with dp on digit 2, committed.
    wr(2'd0, 6'h01); wr(2'd1, 6'h02); wr(2'd2, 6'h13); wr(2'd3, 6'h0A);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1);
    chk("busy_after_commit", 32'(o_busy), 32'd1);
    align(0);
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < FRAME; k++) begin
      idle();
      if (o_anode == 4'b1110 && o_seg == 7'h79) cnt++;
      if (o_anode == 4'b1011 && o_dp == 1'b0) cnt2++;
    end
    chk("dig0_shows_1_cycles", 32'(cnt), 32'd14);
    chk("dig2_dp_cycles", 32'(cnt2), 32'd14);

    // Write 8 to digit 0 without commit: never displayed, never busy.
    wr(2'd0, 6'h08);
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      idle();
      if (o_seg == 7'h00) cnt++;
      if (o_busy) cnt2++;
    end
    chk("no_commit_seg00_cnt", 32'(cnt), 32'd0);
    chk("no_commit_busy_cnt", 32'(cnt2), 32'd0);

    // Commit plus write on the frame_end cycle: active gets pre-write shadow.
    align(FRAME - 1);
    step(1'b0, 1'b1, 2'd1, 6'h0F, 1'b1);
    chk("fe_commit_busy", 32'(o_busy), 32'd0);
    align(P + 5);
    idle();
    chk("fe_dig1_anode", 32'(o_anode), 32'b1101);
    chk("fe_dig1_old_val", 32'(o_seg), 32'h24);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1);
    align(P + 5);
    idle();
    chk("fe_dig1_new_val", 32'(o_seg), 32'h0E);

    // Commit then reset mid digit 2: pending commit lost, display dark.
    wr(2'd2, 6'h07);
    align(10);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1);
    align(2 * P + 5);
    step(1'b1, 1'b0, 2'd0, 6'd0, 1'b0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_dig_sel", 32'(o_dig_sel), 32'd0);
    cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      idle();
      if (o_anode != 4'hF) cnt++;
    end
    chk("midrst_dark_cnt", 32'(cnt), 32'd0);

    // Digit 3 blanked, others visible.
    wr(2'd0, 6'h05); wr(2'd1, 6'h06); wr(2'd2, 6'h07); wr(2'd3, 6'h2C);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1);
    align(0);
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < FRAME; k++) begin
      idle();
      if (o_anode[3] == 1'b0) cnt++;
      if (o_anode == 4'b1110 && o_seg == 7'h12) cnt2++;
    end
    chk("blank_dig3_lit_cnt", 32'(cnt), 32'd0);
    chk("blank_dig0_shows_5", 32'(cnt2), 32'd14);

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
           2'($urandom), 6'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4096, meaning clock cycles per digit slot (power of two, 8..65536).
REQ-002 The block SHALL have parameter BLANK, default 64, meaning dead-time cycles at slot start (1..PRESCALE/2).
REQ-003 clock  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write strobe into shadow digit registers.
REQ-006 wr_addr  input  2  digit index for write (0 = rightmost).
REQ-007 wr_data  input  6  {blank, dp, hex[3:0]} for addressed digit.
REQ-008 commit  input  1  single-cycle request to transfer shadow to active at next frame end.
REQ-009 dig_sel  output  2  currently scanned digit index.
REQ-010 anode  output  4  active-low digit enables, one-hot-low or all-high.
REQ-011 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-012 dp  output  1  active-low decimal point.
REQ-013 busy  output  1  high while a commit is pending.
REQ-014 frame_done  output  1  one-cycle pulse at each frame end.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1, width log2(PRESCALE), and wrap to 0; slot_end is prescaler == PRESCALE-1.
REQ-016 dig_sel SHALL increment modulo 4 on slot_end (3 wraps to 0); frame_end is slot_end with dig_sel == 3.
REQ-017 The FSM SHALL have states BLANK and SHOW; BLANK->SHOW when prescaler == BLANK-1; SHOW->BLANK on slot_end.
REQ-018 In BLANK, anode SHALL be 4'b1111, seg 7'h7F, dp 1.
REQ-019 In SHOW, anode SHALL drive bit dig_sel low only, seg the decoded hex of active[dig_sel], dp = ~active dp bit.
REQ-020 An active digit with blank=1 SHALL produce anode 4'b1111 for its whole slot; timing unchanged.
REQ-021 anode, seg and dp SHALL be registered, lagging state and dig_sel by exactly one cycle.
REQ-022 wr_en SHALL update shadow[wr_addr] with wr_data at the next edge; writes never touch active registers directly.
REQ-023 commit SHALL set busy at the next edge; repeated commit while busy has no further effect.
REQ-024 At frame_end with busy or commit high, all four active registers SHALL load shadow and busy SHALL clear at the same edge.
REQ-025 A write coincident with a frame_end transfer SHALL land in shadow, and active SHALL receive the pre-write shadow value.
REQ-026 frame_done SHALL be registered, high for the cycle after each frame_end, regardless of commit.
REQ-027 Hex decode SHALL be standard: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E (active-low).

Reset
REQ-028 On reset, prescaler and dig_sel SHALL be 0, state BLANK, busy 0, frame_done 0.
REQ-029 On reset, shadow and active registers SHALL be 6'b100000 (blanked, dp off, hex 0).
REQ-030 On reset, anode SHALL be 4'b1111, seg 7'h7F and dp 1 from the first cycle after the reset edge.
REQ-031 Reset mid-frame SHALL discard any pending commit and restart at digit 0, BLANK.

Structure
REQ-032 A shared package SHALL hold the state enum, the 16-entry active-low segment constant table and the 6-bit digit-field offsets.
REQ-033 Hex-to-segment decode SHALL be a separate combinational sub-module, hex7seg.

Verification (bench parameters PRESCALE=16, BLANK=2)
REQ-034 Reset, idle 64 cycles -> anode stays 4'b1111, dig_sel sequence 0,1,2,3,0 at 16-cycle steps, frame_done every 64 cycles.
REQ-035 Write digits 0..3 = hex 1,2,3,A, dp on digit 2, commit -> after next frame_end, digit 0 shows seg 7'h79 for 14 of 16 cycles, and digit 2 shows dp=0.
REQ-036 Write digit 0 = 8 without commit -> seg never shows 7'h00, busy stays 0.
REQ-037 commit and wr_en(addr 1, hex F) on the frame_end cycle -> active digit 1 holds the old shadow value, shadow holds F, busy 0.
REQ-038 commit, then reset at prescaler 5 of digit 2 -> busy 0, all blank, and the next frame shows nothing.
REQ-039 Digit 3 written with blank=1 and committed -> anode[3] never goes low, and other digits are unaffected.
